// File: rtl/vec_regfile_if.sv
// Vector register file bus: read addresses and operands, the lane-masked write
// port, the clear request and the busy flag seen by the issue stage.
interface vec_regfile_if #(
  parameter int LANES           = 16,
  parameter int LANE_WIDTH      = 32,
  parameter int VEC_INDEX_WIDTH = 3,
  parameter int READ_PORTS      = 2
);
  logic [READ_PORTS-1:0][VEC_INDEX_WIDTH-1:0]         i_read_addr;
  logic [READ_PORTS-1:0][LANES-1:0][LANE_WIDTH-1:0]   o_read_data;
  logic                                               i_write_enable;
  logic [VEC_INDEX_WIDTH-1:0]                         i_write_addr;
  logic [LANES-1:0]                                   i_write_mask;
  logic [LANES-1:0][LANE_WIDTH-1:0]                   i_write_data;
  logic                                               i_clear_req;
  logic                                               o_busy;

  // Decode / ALU side: issues addresses and write data, consumes operands.
  modport master (
    output i_read_addr,
    output i_write_enable,
    output i_write_addr,
    output i_write_mask,
    output i_write_data,
    output i_clear_req,
    input  o_read_data,
    input  o_busy
  );

  // Register file side.
  modport slave (
    input  i_read_addr,
    input  i_write_enable,
    input  i_write_addr,
    input  i_write_mask,
    input  i_write_data,
    input  i_clear_req,
    output o_read_data,
    output o_busy
  );
endinterface

// File: rtl/vec_regfile.sv
// Vector register file: DEPTH entries of LANES x LANE_WIDTH bits, READ_PORTS
// registered read ports, one lane-masked write port with write-to-read bypass,
// and a clear engine that zeroes every entry after reset or on request.
module vec_regfile #(
  parameter int LANES           = 16,
  parameter int LANE_WIDTH      = 32,
  parameter int VEC_INDEX_WIDTH = 3,
  parameter int READ_PORTS      = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  vec_regfile_if.slave  bus
);

  localparam int DEPTH = 1 << VEC_INDEX_WIDTH;
  localparam logic [VEC_INDEX_WIDTH-1:0] IDX_ONE  = VEC_INDEX_WIDTH'(1);
  localparam logic [VEC_INDEX_WIDTH-1:0] IDX_LAST = VEC_INDEX_WIDTH'(DEPTH - 1);

  typedef logic [LANES-1:0][LANE_WIDTH-1:0] vec_t;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  // Lane-wise select: new data where the mask bit is set, old data elsewhere.
  function automatic vec_t lane_merge(input vec_t old_v, input vec_t new_v,
                                      input logic [LANES-1:0] mask);
    vec_t res;
    for (int l = 0; l < LANES; l++) begin
      res[l] = mask[l] ? new_v[l] : old_v[l];
    end
    return res;
  endfunction

  state_t                                           r_state;
  logic [VEC_INDEX_WIDTH-1:0]                       r_clr_idx;
  logic                                             r_busy;
  vec_t                                             r_mem [DEPTH];
  logic [READ_PORTS-1:0][LANES-1:0][LANE_WIDTH-1:0] r_read_data_p1;

  vec_t                                             w_merged;
  logic [READ_PORTS-1:0][LANES-1:0][LANE_WIDTH-1:0] w_rd_next;

  // Post-write contents of the addressed entry; feeds both the array and bypass.
  always_comb begin
    w_merged = lane_merge(r_mem[bus.i_write_addr], bus.i_write_data, bus.i_write_mask);
  end

  // Per-port read selection: zero while clearing, bypass on address match.
  always_comb begin
    w_rd_next = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (r_state == ST_CLEAR) begin
        w_rd_next[p] = '0;
      end else if (bus.i_write_enable && (bus.i_read_addr[p] == bus.i_write_addr)) begin
        w_rd_next[p] = w_merged;
      end else begin
        w_rd_next[p] = r_mem[bus.i_read_addr[p]];
      end
    end
  end

  // Clear engine FSM: walks clr_idx through every entry, then idles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + IDX_ONE;
          if (r_clr_idx == IDX_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.i_clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_idx <= '0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: no reset; the clear engine owns zeroing, writes only in IDLE.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (bus.i_write_enable) begin
      r_mem[bus.i_write_addr] <= w_merged;
    end
  end

  // ---- stage p1: registered read operands ----
  // Read data register; reset forces all operands to zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_read_data_p1 <= '0;
    end else begin
      r_read_data_p1 <= w_rd_next;
    end
  end

  assign bus.o_read_data = r_read_data_p1;
  assign bus.o_busy      = r_busy;

endmodule
